fill_rect: RTL and testbench

- Parametrised rectangle filler that drives the VGA adapter's pixel-write port (x, y, colour, plot).
- Generalises the full-screen fill to:
  - any axis-aligned rectangle given by two corners, accepted in any order;
  - solid or outline mode;
  - configurable screen size and colour depth.
- Sits between game-master drawing logic and the VGA adapter. It is the common primitive for clearing the screen, drawing sprite backgrounds and drawing borders.

---
 rtl/fill_pkg.sv | 21 ++
 rtl/rect_clip.sv | 41 ++++
 rtl/fill_rect.sv | 145 ++++++++++++++
 tb/tb_fill_rect.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared state encoding and default screen geometry for the rectangle filler.
`default_nettype none

package fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PLOT  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;
  localparam int DEF_COLOUR_W = 3;

endpackage

`default_nettype wire

// File: rtl/rect_clip.sv
// Combinational corner normalisation and screen clipping for fill_rect.
`default_nettype none

module rect_clip
  import fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W
) (
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x_lo,
  output logic [X_W-1:0] x_hi,
  output logic [Y_W-1:0] y_lo,
  output logic [Y_W-1:0] y_hi,
  output logic           empty
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] x_hi_raw;
  logic [Y_W-1:0] y_hi_raw;

  assign x_lo     = (x0 < x1) ? x0 : x1;
  assign x_hi_raw = (x0 < x1) ? x1 : x0;
  assign y_lo     = (y0 < y1) ? y0 : y1;
  assign y_hi_raw = (y0 < y1) ? y1 : y0;

  // Only the far corner is clipped; a near corner past the edge means nothing is visible.
  assign x_hi  = (x_hi_raw > X_MAX) ? X_MAX : x_hi_raw;
  assign y_hi  = (y_hi_raw > Y_MAX) ? Y_MAX : y_hi_raw;
  assign empty = (x_lo > X_MAX) || (y_lo > Y_MAX);

endmodule

`default_nettype wire

// File: rtl/fill_rect.sv
// Rectangle filler (solid or outline) driving the VGA adapter pixel-write port.
`default_nettype none

module fill_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                outline,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  fill_state_t         state;
  logic [X_W-1:0]      ax, bx, cx, x_lo_r, x_hi_r;
  logic [Y_W-1:0]      ay, by, cy, y_lo_r, y_hi_r;
  logic [COLOUR_W-1:0] colour_r;
  logic                outline_r;

  logic [X_W-1:0] clip_x_lo, clip_x_hi;
  logic [Y_W-1:0] clip_y_lo, clip_y_hi;
  logic           clip_empty;

  rect_clip #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_clip (
    .x0   (ax),
    .y0   (ay),
    .x1   (bx),
    .y1   (by),
    .x_lo (clip_x_lo),
    .x_hi (clip_x_hi),
    .y_lo (clip_y_lo),
    .y_hi (clip_y_hi),
    .empty(clip_empty)
  );

  logic row_end, last_px, interior_row;

  assign row_end      = (cx == x_hi_r);
  assign last_px      = row_end && (cy == y_hi_r);
  assign interior_row = (cy != y_lo_r) && (cy != y_hi_r);

  // The pixel counters double as the output coordinates, so they hold outside PLOT.
  assign vga_x = cx;
  assign vga_y = cy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ax         <= '0;
      ay         <= '0;
      bx         <= '0;
      by         <= '0;
      colour_r   <= '0;
      outline_r  <= 1'b0;
      x_lo_r     <= '0;
      x_hi_r     <= '0;
      y_lo_r     <= '0;
      y_hi_r     <= '0;
      cx         <= '0;
      cy         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ax        <= x0;
            ay        <= y0;
            bx        <= x1;
            by        <= y1;
            colour_r  <= colour;
            outline_r <= outline;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          x_lo_r <= clip_x_lo;
          x_hi_r <= clip_x_hi;
          y_lo_r <= clip_y_lo;
          y_hi_r <= clip_y_hi;
          if (clip_empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cx         <= clip_x_lo;
            cy         <= clip_y_lo;
            vga_colour <= colour_r;
            vga_plot   <= 1'b1;
            state      <= PLOT;
          end
        end
        PLOT: begin
          if (last_px) begin
            vga_plot <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (row_end) begin
            cx <= x_lo_r;
            cy <= cy + 1'b1;
          end else if (outline_r && interior_row && (cx == x_lo_r)) begin
            cx <= x_hi_r;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fill_rect.sv
// Directed self-checking bench for fill_rect: fills, outline, clipping, reset and handshake.
`default_nettype none

module tb_fill_rect;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] x0, x1;
  logic [7:0] y0, y1;
  logic [2:0] colour;
  logic       outline;
  logic       busy, done, vga_plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;

  pix_t cap[$];
  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fill_rect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .colour    (colour),
    .outline   (outline),
    .busy      (busy),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vga_plot) cap.push_back('{x: vga_x, y: vga_y, c: vga_colour});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one fill and compares the captured pixel stream with a row/column scan of the
  // expected rectangle; pulse_at > 0 re-pulses start with other corners while busy.
  task automatic run_fill(input string tag, input int ax, input int ay, input int bx,
                          input int by, input int col, input int outl, input int xl,
                          input int xh, input int yl, input int yh, input int exp_n,
                          input bit hold, input int pulse_at);
    int   edges;
    int   errs;
    pix_t p;
    exp_q.delete();
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (outl == 0 || y == yl || y == yh || x == xl || x == xh) begin
          p.x = x[8:0];
          p.y = y[7:0];
          p.c = col[2:0];
          exp_q.push_back(p);
        end
      end
    end
    @(negedge clk);
    x0 = 9'(ax); y0 = 8'(ay); x1 = 9'(bx); y1 = 8'(by);
    colour = 3'(col); outline = (outl != 0); start = 1'b1;
    cap.delete();
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    x0 = 9'd111; y0 = 8'd77; x1 = 9'd3; y1 = 8'd4; colour = 3'd6; outline = ~outline;
    check({tag, "_busy_setup"}, busy, 1);
    edges = 0;
    while (!done && edges < exp_n + 50) begin
      @(posedge clk);
      #1;
      edges++;
      if (pulse_at > 0 && edges == pulse_at) start = 1'b1;
      else if (pulse_at > 0 && edges == pulse_at + 1) start = 1'b0;
    end
    check({tag, "_latency"}, edges, exp_n + 1);
    check({tag, "_count"}, cap.size(), exp_n);
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= cap.size() || cap[i] !== exp_q[i]) errs++;
    end
    check({tag, "_pixel_errs"}, errs, 0);
    check({tag, "_done_busy"}, {done, busy, vga_plot}, 3'b100);
    if (!hold) begin
      @(posedge clk);
      #1;
      check({tag, "_idle"}, done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; outline = 1'b0; colour = '0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #1;
    check("reset_flags", {busy, done, vga_plot}, 3'b000);
    check("reset_xy", {vga_x, vga_y, vga_colour}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_fill("full", 0, 0, 319, 239, 5, 0, 0, 319, 0, 239, 76800, 1'b0, 0);
    run_fill("swap", 10, 20, 7, 18, 2, 0, 7, 10, 18, 20, 12, 1'b0, 0);
    check("swap_first", {cap[0].x, cap[0].y}, {9'd7, 8'd18});
    check("swap_last", {cap[11].x, cap[11].y}, {9'd10, 8'd20});
    run_fill("outline", 2, 2, 5, 5, 3, 1, 2, 5, 2, 5, 12, 1'b0, 0);
    run_fill("clip", 315, 235, 400, 250, 4, 0, 315, 319, 235, 239, 25, 1'b0, 0);
    check("clip_last", {cap[24].x, cap[24].y}, {9'd319, 8'd239});
    run_fill("empty", 330, 0, 340, 10, 1, 0, 330, 319, 0, 10, 0, 1'b0, 0);

    // Asynchronous reset in the middle of a full-screen fill.
    @(negedge clk);
    x0 = 9'd0; y0 = 8'd0; x1 = 9'd319; y1 = 8'd239; colour = 3'd7; outline = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {busy, done, vga_plot}, 3'b000);
    check("rst_mid_xy", {vga_x, vga_y, vga_colour}, 0);
    cap.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_plots", cap.size(), 0);
    check("rst_idle", {busy, done}, 2'b00);

    // start held high across a 1x1 fill must not retrigger.
    run_fill("hold", 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 1'b1, 0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_done_stays", {done, busy}, 2'b10);
    check("hold_no_retrigger", cap.size(), 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold_release_idle", {done, busy}, 2'b00);

    run_fill("pulse_busy", 2, 2, 5, 5, 6, 0, 2, 5, 2, 5, 16, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
